// File: rtl/fpu_sequencer_pkg.sv
// ==========================================================================
// fpu_pkg : shared types and constants for the FPU issue sequencer
// Revision: 1.0
// ==========================================================================
`default_nettype none

package fpu_pkg;

  typedef enum logic [1:0] {
    FST_NONE  = 2'b00,
    FST_SHORT = 2'b01,
    FST_SQRT  = 2'b10,
    FST_DIV   = 2'b11
  } fpu_stall_t;

  localparam logic [3:0] FOP_FADD  = 4'b0000;
  localparam logic [3:0] FOP_FSUB  = 4'b0001;
  localparam logic [3:0] FOP_FMUL  = 4'b0010;
  localparam logic [3:0] FOP_FDIV  = 4'b0011;
  localparam logic [3:0] FOP_FSQRT = 4'b0100;
  localparam logic [3:0] FOP_FLOOR = 4'b0101;
  localparam logic [3:0] FOP_FTOI  = 4'b0110;
  localparam logic [3:0] FOP_ITOF  = 4'b0111;
  localparam logic [3:0] FOP_FEQ   = 4'b1000;
  localparam logic [3:0] FOP_FLESS = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  // Largest of the three class latencies; sizes the latency counter.
  function automatic int lat_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_sequencer_lat_counter.sv
// ==========================================================================
// fpu_lat_counter : loadable down-counter flagging the final FPU cycle
// Revision: 1.0
// ==========================================================================
`default_nettype none

module fpu_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Holds at zero once drained so an idle counter never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/fpu_sequencer.sv
// ==========================================================================
// fpu_sequencer : multi-cycle FPU issue/stall/write-back controller
// Optional: FPU_PERF_CNT_EN adds the saturating stall_cycles counter port.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int LAT_SHORT = 2,
  parameter int LAT_SQRT  = 8,
  parameter int LAT_DIV   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [3:0]  fpucontrol,
  input  logic [1:0]  fpustall,
  input  logic [4:0]  rd,
  input  logic        flush,
`ifdef FPU_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        stall,
  output logic        busy,
  output logic        fpu_start,
  output logic [3:0]  fpu_op,
  output logic        wb_en,
  output logic [4:0]  wb_rd
);

  localparam int CNT_W = $clog2(lat_max(LAT_SHORT, LAT_SQRT, LAT_DIV) + 1);

  seq_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             fpu_start_q, fpu_start_d;
  logic [3:0]       fpu_op_q, fpu_op_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             accept;
  logic             cnt_last;
  logic [CNT_W-1:0] lat_value;

  assign accept = (state_q == IDLE) & issue & (fpustall != FST_NONE) & ~flush;

  always_comb begin
    lat_value = CNT_W'(LAT_SHORT);
    case (fpu_stall_t'(fpustall))
      FST_SQRT: lat_value = CNT_W'(LAT_SQRT);
      FST_DIV:  lat_value = CNT_W'(LAT_DIV);
      default:  lat_value = CNT_W'(LAT_SHORT);
    endcase
  end

  fpu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .value (lat_value),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      fpu_start_q <= 1'b0;
      fpu_op_q    <= 4'd0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      fpu_start_q <= fpu_start_d;
      fpu_op_q    <= fpu_op_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  // DONE ignores flush and issue: the op has committed and the EX instruction is its owner.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall       = accept | (state_q == BUSY);
    busy_d      = (state_d == BUSY);
    fpu_start_d = accept;
    wb_en_d     = (state_q == BUSY) & cnt_last & ~flush;
    fpu_op_d    = accept ? fpucontrol : fpu_op_q;
    wb_rd_d     = accept ? rd : wb_rd_q;
  end

  assign busy      = busy_q;
  assign fpu_start = fpu_start_q;
  assign fpu_op    = fpu_op_q;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;

`ifdef FPU_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_sequencer.sv
// ==========================================================================
// tb_fpu_sequencer : directed + random checks of fpu_sequencer against a
// transaction-timeline reference model.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue;
  logic [3:0]  fpucontrol;
  logic [1:0]  fpustall;
  logic [4:0]  rd;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        fpu_start;
  logic [3:0]  fpu_op;
  logic        wb_en;
  logic [4:0]  wb_rd;
`ifdef FPU_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  fpu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .issue        (issue),
    .fpucontrol   (fpucontrol),
    .fpustall     (fpustall),
    .rd           (rd),
    .flush        (flush),
`ifdef FPU_PERF_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .stall        (stall),
    .busy         (busy),
    .fpu_start    (fpu_start),
    .fpu_op       (fpu_op),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the in-flight op is described by its accept cycle and latency.
  int          n     = 0;
  bit          act   = 0;
  int          t0    = 0;
  int          lat   = 0;
  logic [3:0]  op_h  = 4'd0;
  logic [4:0]  rd_h  = 5'd0;
  longint      pc    = 0;

  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'b01:   return 2;
      2'b10:   return 8;
      2'b11:   return 12;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic step(input logic i_iss, input logic [1:0] i_cls, input logic [3:0] i_op,
                      input logic [4:0] i_rd, input logic i_fl, input logic i_rst);
    int   rel;
    logic in_busy, in_done, acc, e_stall;
    issue      = i_iss;
    fpustall   = i_cls;
    fpucontrol = i_op;
    rd         = i_rd;
    flush      = i_fl;
    reset      = i_rst;
    #2;
    rel     = n - t0;
    in_busy = act && (rel >= 1) && (rel <= lat);
    in_done = act && (rel == lat + 1);
    acc     = !in_busy && !in_done && i_iss && (i_cls != 2'b00) && !i_fl;
    e_stall = in_busy || acc;
    chk("stall",     32'(stall),     32'(e_stall));
    chk("busy",      32'(busy),      32'(in_busy));
    chk("fpu_start", 32'(fpu_start), 32'(in_busy && (rel == 1)));
    chk("wb_en",     32'(wb_en),     32'(in_done));
    chk("fpu_op",    32'(fpu_op),    32'(op_h));
    chk("wb_rd",     32'(wb_rd),     32'(rd_h));
`ifdef FPU_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, 32'(pc));
`endif
    if (i_rst) begin
      act  = 0;
      op_h = 4'd0;
      rd_h = 5'd0;
      pc   = 0;
    end else begin
      if (e_stall && pc < 64'hFFFF_FFFF) pc = pc + 1;
      if (acc) begin
        act  = 1;
        t0   = n;
        lat  = lat_of(i_cls);
        op_h = i_op;
        rd_h = i_rd;
      end else if ((in_busy && i_fl) || in_done) begin
        act = 0;
      end
    end
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 2'b00, 4'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] r_cls;
    logic [3:0] r_op;
    logic [4:0] r_rd;
    logic       r_iss, r_fl, r_rst;

    reset = 1'b1; issue = 1'b0; fpucontrol = 4'd0; fpustall = 2'b00; rd = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then fmul (class 01) held in EX through its DONE cycle.
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 4'b0010, 5'd7, 1'b0, 1'b0);
    idle(1);

    // fdiv followed back-to-back by fsqrt.
    for (int i = 0; i < 14; i++) step(1'b1, 2'b11, 4'b0011, 5'd3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b10, 4'b0100, 5'd9, 1'b0, 1'b0);
    idle(1);

    // Single-cycle feq never engages the sequencer.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 4'b1000, 5'd12, 1'b0, 1'b0);

    // fdiv flushed at T+5; then fadd with flush landing in DONE.
    for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 4'b0011, 5'd20, 1'b0, 1'b0);
    step(1'b1, 2'b11, 4'b0011, 5'd20, 1'b1, 1'b0);
    idle(14);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 4'b0000, 5'd5, 1'b0, 1'b0);
    step(1'b1, 2'b01, 4'b0000, 5'd5, 1'b1, 1'b0);
    idle(1);

    // Reset, then one clean fadd for the stall counter.
    step(1'b0, 2'b00, 4'd0, 5'd0, 1'b0, 1'b1);
`ifdef FPU_PERF_CNT_EN
    chk("perf_after_reset", stall_cycles, 32'd0);
`endif
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 4'b0000, 5'd1, 1'b0, 1'b0);
`ifdef FPU_PERF_CNT_EN
    chk("perf_one_fadd", stall_cycles, 32'd3);
`endif

    // fadd aborted by reset in its first BUSY cycle.
    step(1'b1, 2'b01, 4'b0000, 5'd30, 1'b0, 1'b0);
    step(1'b1, 2'b01, 4'b0000, 5'd30, 1'b0, 1'b1);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r_cls = 2'($urandom_range(0, 3));
      r_op  = (r_cls == 2'b00) ? 4'(8 + $urandom_range(0, 1)) : 4'($urandom_range(0, 7));
      r_rd  = 5'($urandom_range(0, 31));
      r_iss = ($urandom_range(0, 9) < 7);
      r_fl  = ($urandom_range(0, 15) == 0);
      r_rst = ($urandom_range(0, 63) == 0);
      step(r_iss, r_cls, r_op, r_rd, r_fl, r_rst);
    end
    idle(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
